top_uart: RTL and testbench

- Top-level UART telemetry block for the vital-signs monitor.
- Periodically transmits heart-rate and SpO2 readings as an ASCII line over an 8N1 UART.
- Drives two alarm LEDs from threshold checks on those readings.
- Accepts single-byte commands on the UART receive line to mute or unmute the alarm LEDs.

---
 rtl/top_uart.sv | 235 +++++++++++++++++++++++
 tb/tb_top_uart.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/top_uart.sv
// Vital-signs UART telemetry: periodic "HR:ddd SP:ddd\r\n" frames on tx,
// registered threshold alarms on two LEDs, and mute/unmute/force commands on rx.
module top_uart #(
   parameter int CLK_FREQ      = 100_000_000,
   parameter int BAUD          = 9600,
   parameter int TX_GAP_CYCLES = 100_000,
   parameter int HR_LOW        = 50,
   parameter int HR_HIGH       = 120,
   parameter int SPO2_LOW      = 90
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] data_heart_rate,
   input  logic [7:0]  data_spo2,
   input  logic        rx,
   output logic        tx,
   output logic        led_1,
   output logic        led_2
);

   localparam int BIT_DIV  = (CLK_FREQ + BAUD / 2) / BAUD;
   localparam int HALF_DIV = BIT_DIV / 2;
   localparam int BW       = $clog2(BIT_DIV + 1);
   localparam int GW       = $clog2(TX_GAP_CYCLES + 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(BIT_DIV - 1);
   localparam logic [BW-1:0] HALF_LAST = BW'(HALF_DIV - 1);
   localparam logic [GW-1:0] GAP_LAST  = GW'(TX_GAP_CYCLES - 1);

   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_t;
   typedef enum logic [1:0] {TX_GAP, TX_LOAD, TX_SEND, TX_WAIT} tx_state_t;

   logic            rx_meta_q, rx_sync_q;
   rx_state_t       rx_state_q;
   logic [BW-1:0]   rx_cnt_q;
   logic [2:0]      rx_bit_q;
   logic [7:0]      rx_shift_q, rx_byte_q;
   logic            rx_valid_q;

   logic            hr_alarm_q, spo2_alarm_q, mute_q, led_1_q, led_2_q;

   tx_state_t       tx_state_q;
   logic [GW-1:0]   gap_cnt_q;
   logic [4:0]      conv_cnt_q;
   logic [9:0]      hr_rem_q, sp_rem_q;
   logic [3:0]      hr_d2_q, hr_d1_q, sp_d2_q, sp_d1_q;
   logic [3:0]      idx_q;
   logic [8:0]      tx_shift_q;
   logic [3:0]      tx_bit_q;
   logic [BW-1:0]   tx_cnt_q;
   logic            tx_q;

   logic [3:0]      sel_idx_d;
   logic [7:0]      byte_d;
   logic [9:0]      hr_sat_d;
   logic            cmd_force_d;

   assign tx    = tx_q;
   assign led_1 = led_1_q;
   assign led_2 = led_2_q;

   assign hr_sat_d    = (data_heart_rate > 16'd999) ? 10'd999 : data_heart_rate[9:0];
   assign cmd_force_d = rx_valid_q && (rx_byte_q == 8'h52);
   // SEND loads the current byte; WAIT preloads the following one at stop-bit end.
   assign sel_idx_d   = (tx_state_q == TX_SEND) ? idx_q : idx_q + 4'd1;

   always_comb begin
      byte_d = 8'h0A;
      case (sel_idx_d)
         4'd0:    byte_d = 8'h48;
         4'd1:    byte_d = 8'h52;
         4'd2:    byte_d = 8'h3A;
         4'd3:    byte_d = 8'h30 + {4'h0, hr_d2_q};
         4'd4:    byte_d = 8'h30 + {4'h0, hr_d1_q};
         4'd5:    byte_d = 8'h30 + {4'h0, hr_rem_q[3:0]};
         4'd6:    byte_d = 8'h20;
         4'd7:    byte_d = 8'h53;
         4'd8:    byte_d = 8'h50;
         4'd9:    byte_d = 8'h3A;
         4'd10:   byte_d = 8'h30 + {4'h0, sp_d2_q};
         4'd11:   byte_d = 8'h30 + {4'h0, sp_d1_q};
         4'd12:   byte_d = 8'h30 + {4'h0, sp_rem_q[3:0]};
         4'd13:   byte_d = 8'h0D;
         default: byte_d = 8'h0A;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hr_alarm_q   <= 1'b0;
         spo2_alarm_q <= 1'b0;
         mute_q       <= 1'b0;
         led_1_q      <= 1'b0;
         led_2_q      <= 1'b0;
      end else begin
         hr_alarm_q   <= (data_heart_rate < 16'(HR_LOW)) || (data_heart_rate > 16'(HR_HIGH));
         spo2_alarm_q <= data_spo2 < 8'(SPO2_LOW);
         led_1_q      <= hr_alarm_q & ~mute_q;
         led_2_q      <= spo2_alarm_q & ~mute_q;
         if (rx_valid_q && rx_byte_q == 8'h4D) mute_q <= 1'b1;
         else if (rx_valid_q && rx_byte_q == 8'h55) mute_q <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta_q  <= 1'b1;
         rx_sync_q  <= 1'b1;
         rx_state_q <= RX_IDLE;
         rx_cnt_q   <= '0;
         rx_bit_q   <= '0;
         rx_shift_q <= '0;
         rx_byte_q  <= '0;
         rx_valid_q <= 1'b0;
      end else begin
         rx_meta_q  <= rx;
         rx_sync_q  <= rx_meta_q;
         rx_valid_q <= 1'b0;
         case (rx_state_q)
            // IDLE is only entered with the line high, so a low level is a falling edge.
            RX_IDLE: if (!rx_sync_q) begin
               rx_cnt_q   <= '0;
               rx_state_q <= RX_START;
            end
            RX_START: if (rx_cnt_q == HALF_LAST) begin
               rx_cnt_q   <= '0;
               rx_bit_q   <= '0;
               rx_state_q <= rx_sync_q ? RX_IDLE : RX_DATA;
            end else rx_cnt_q <= rx_cnt_q + 1'b1;
            RX_DATA: if (rx_cnt_q == BIT_LAST) begin
               rx_cnt_q   <= '0;
               rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
               rx_bit_q   <= rx_bit_q + 3'd1;
               if (rx_bit_q == 3'd7) rx_state_q <= RX_STOP;
            end else rx_cnt_q <= rx_cnt_q + 1'b1;
            RX_STOP: if (rx_cnt_q == BIT_LAST) begin
               rx_cnt_q <= '0;
               if (rx_sync_q) begin
                  rx_valid_q <= 1'b1;
                  rx_byte_q  <= rx_shift_q;
                  rx_state_q <= RX_IDLE;
               end else rx_state_q <= RX_WAIT_HIGH;
            end else rx_cnt_q <= rx_cnt_q + 1'b1;
            RX_WAIT_HIGH: if (rx_sync_q) rx_state_q <= RX_IDLE;
            default: rx_state_q <= RX_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_state_q <= TX_GAP;
         gap_cnt_q  <= '0;
         conv_cnt_q <= '0;
         hr_rem_q   <= '0;
         sp_rem_q   <= '0;
         hr_d2_q    <= '0;
         hr_d1_q    <= '0;
         sp_d2_q    <= '0;
         sp_d1_q    <= '0;
         idx_q      <= '0;
         tx_shift_q <= '1;
         tx_bit_q   <= '0;
         tx_cnt_q   <= '0;
         tx_q       <= 1'b1;
      end else begin
         case (tx_state_q)
            TX_GAP: if (cmd_force_d || gap_cnt_q == GAP_LAST) begin
               gap_cnt_q  <= '0;
               conv_cnt_q <= '0;
               tx_state_q <= TX_LOAD;
            end else gap_cnt_q <= gap_cnt_q + 1'b1;
            // Cycle 0 samples; cycles 1-9 peel hundreds, 10-18 tens; remainder is ones.
            TX_LOAD: begin
               conv_cnt_q <= conv_cnt_q + 5'd1;
               if (conv_cnt_q == 5'd0) begin
                  hr_rem_q <= hr_sat_d;
                  sp_rem_q <= {2'b00, data_spo2};
                  hr_d2_q  <= '0;
                  hr_d1_q  <= '0;
                  sp_d2_q  <= '0;
                  sp_d1_q  <= '0;
               end else if (conv_cnt_q <= 5'd9) begin
                  if (hr_rem_q >= 10'd100) begin
                     hr_rem_q <= hr_rem_q - 10'd100;
                     hr_d2_q  <= hr_d2_q + 4'd1;
                  end
                  if (sp_rem_q >= 10'd100) begin
                     sp_rem_q <= sp_rem_q - 10'd100;
                     sp_d2_q  <= sp_d2_q + 4'd1;
                  end
               end else if (conv_cnt_q <= 5'd18) begin
                  if (hr_rem_q >= 10'd10) begin
                     hr_rem_q <= hr_rem_q - 10'd10;
                     hr_d1_q  <= hr_d1_q + 4'd1;
                  end
                  if (sp_rem_q >= 10'd10) begin
                     sp_rem_q <= sp_rem_q - 10'd10;
                     sp_d1_q  <= sp_d1_q + 4'd1;
                  end
               end else begin
                  idx_q      <= '0;
                  tx_state_q <= TX_SEND;
               end
            end
            TX_SEND: begin
               tx_shift_q <= {1'b1, byte_d};
               tx_q       <= 1'b0;
               tx_bit_q   <= '0;
               tx_cnt_q   <= '0;
               tx_state_q <= TX_WAIT;
            end
            TX_WAIT: if (tx_cnt_q == BIT_LAST) begin
               tx_cnt_q <= '0;
               if (tx_bit_q == 4'd9) begin
                  if (idx_q == 4'd14) begin
                     gap_cnt_q  <= '0;
                     tx_state_q <= TX_GAP;
                  end else begin
                     idx_q      <= idx_q + 4'd1;
                     tx_shift_q <= {1'b1, byte_d};
                     tx_q       <= 1'b0;
                     tx_bit_q   <= '0;
                  end
               end else begin
                  tx_q       <= tx_shift_q[0];
                  tx_shift_q <= {1'b1, tx_shift_q[8:1]};
                  tx_bit_q   <= tx_bit_q + 4'd1;
               end
            end else tx_cnt_q <= tx_cnt_q + 1'b1;
            default: tx_state_q <= TX_GAP;
         endcase
      end
   end

endmodule

// File: tb/tb_top_uart.sv
// Bench for top_uart: decodes tx against an expected-byte queue and checks
// LED alarms, mute commands, forced frames and reset behaviour.
module tb_top_uart;

   localparam int CLK_FREQ = 1_600_000;
   localparam int BAUD     = 100_000;
   localparam int BIT_DIV  = 16;
   localparam int TX_GAP   = 400;

   logic        clk;
   logic        rst_n;
   logic [15:0] hr;
   logic [7:0]  sp;
   logic        rx;
   logic        tx;
   logic        led_1;
   logic        led_2;

   logic [7:0]  exp_q[$];
   int          vectors = 0;
   int          errors  = 0;

   top_uart #(
      .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .TX_GAP_CYCLES(TX_GAP),
      .HR_LOW(50), .HR_HIGH(120), .SPO2_LOW(90)
   ) dut (
      .clk(clk), .rst_n(rst_n), .data_heart_rate(hr), .data_spo2(sp),
      .rx(rx), .tx(tx), .led_1(led_1), .led_2(led_2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic expect_frame(input int hr_v, input int sp_v);
      int h;
      h = (hr_v > 999) ? 999 : hr_v;
      exp_q.push_back(8'h48); exp_q.push_back(8'h52); exp_q.push_back(8'h3A);
      exp_q.push_back(8'(48 + h / 100));
      exp_q.push_back(8'(48 + (h / 10) % 10));
      exp_q.push_back(8'(48 + h % 10));
      exp_q.push_back(8'h20); exp_q.push_back(8'h53); exp_q.push_back(8'h50);
      exp_q.push_back(8'h3A);
      exp_q.push_back(8'(48 + sp_v / 100));
      exp_q.push_back(8'(48 + (sp_v / 10) % 10));
      exp_q.push_back(8'(48 + sp_v % 10));
      exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      rx = 1'b0;
      cycles(BIT_DIV);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         cycles(BIT_DIV);
      end
      rx = stop_bit;
      cycles(BIT_DIV);
      rx = 1'b1;
   endtask

   task automatic wait_frame_done();
      int n = 0;
      while (exp_q.size() != 0 && n < 6000) begin
         @(negedge clk);
         n++;
      end
      check("frame_done_left", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
   endtask

   task automatic wait_tx_low(input int budget, output logic found);
      found = 1'b0;
      for (int n = 0; n < budget && !found; n++) begin
         @(negedge clk);
         if (tx === 1'b0) found = 1'b1;
      end
   endtask

   task automatic check_leds(input string tag, input logic e1, input logic e2);
      check({tag, "_led1"}, {31'd0, led_1}, {31'd0, e1});
      check({tag, "_led2"}, {31'd0, led_2}, {31'd0, e2});
   endtask

   always begin : tx_monitor
      logic [7:0] b;
      @(negedge clk);
      if (rst_n === 1'b1 && tx === 1'b0) begin
         b = '0;
         cycles(BIT_DIV / 2);
         for (int i = 0; i < 8; i++) begin
            cycles(BIT_DIV);
            b = {tx, b[7:1]};
         end
         cycles(BIT_DIV);
         check("tx_stop_bit", {31'd0, tx}, 32'd1);
         if (exp_q.size() == 0) check("tx_unexpected_byte", {24'd0, b}, 32'hFFFF_FFFF);
         else check("tx_byte", {24'd0, b}, {24'd0, exp_q.pop_front()});
      end
   end

   initial begin
      logic found;
      int   lows;
      int   n;
      int   bnd_hr[5] = '{50, 120, 49, 121, 75};
      int   bnd_sp[5] = '{90, 90, 89, 89, 98};
      logic bnd_l1[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      logic bnd_l2[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

      rst_n = 1'b0;
      rx    = 1'b1;
      hr    = 16'd75;
      sp    = 8'd98;
      #100;
      check("reset_tx", {31'd0, tx}, 32'd1);
      check_leds("reset", 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      // first frame: quiet gap, then conversion latency, then 75/98
      expect_frame(75, 98);
      lows = 0;
      for (int i = 0; i < TX_GAP; i++) begin
         @(negedge clk);
         if (tx === 1'b0) lows++;
      end
      check("gap_quiet_lows", 32'(lows), 32'd0);
      wait_tx_low(60, found);
      check("first_frame_start", {31'd0, found}, 32'd1);
      wait_frame_done();
      check_leds("normal", 1'b0, 1'b0);

      // alarm latency, then a frame whose inputs change mid-frame
      hr = 16'd125;
      sp = 8'd80;
      @(negedge clk);
      check_leds("lat1", 1'b0, 1'b0);
      @(negedge clk);
      check_leds("lat2", 1'b1, 1'b1);
      expect_frame(125, 80);
      n = 0;
      while (exp_q.size() > 12 && n < 4000) begin
         @(negedge clk);
         n++;
      end
      check("frame2_started", {31'd0, exp_q.size() <= 12}, 32'd1);
      hr = 16'd1500;
      sp = 8'd80;

      send_byte(8'h4D, 1'b1);
      cycles(BIT_DIV);
      check_leds("mute", 1'b0, 1'b0);
      send_byte(8'h55, 1'b1);
      cycles(BIT_DIV);
      check_leds("unmute", 1'b1, 1'b1);
      send_byte(8'h4D, 1'b0);
      cycles(2 * BIT_DIV);
      check_leds("framing_err", 1'b1, 1'b1);
      rx = 1'b0;
      cycles(3);
      rx = 1'b1;
      cycles(2 * BIT_DIV);
      send_byte(8'h4D, 1'b1);
      cycles(BIT_DIV);
      check_leds("glitch_then_mute", 1'b0, 1'b0);
      send_byte(8'h55, 1'b1);
      cycles(BIT_DIV);
      check_leds("unmute2", 1'b1, 1'b1);
      send_byte(8'h52, 1'b1);
      wait_frame_done();

      // 'R' during GAP starts the next frame well before the gap expires
      expect_frame(1500, 80);
      send_byte(8'h52, 1'b1);
      wait_tx_low(100, found);
      check("force_frame_start", {31'd0, found}, 32'd1);
      wait_frame_done();

      for (int i = 0; i < 5; i++) begin
         hr = 16'(bnd_hr[i]);
         sp = 8'(bnd_sp[i]);
         cycles(2);
         check_leds($sformatf("bound_hr%0d_sp%0d", bnd_hr[i], bnd_sp[i]), bnd_l1[i], bnd_l2[i]);
      end
      hr = 16'd1500;
      sp = 8'd89;
      expect_frame(1500, 89);
      wait_frame_done();

      // reset in the middle of a start bit
      wait_tx_low(600, found);
      check("last_frame_start", {31'd0, found}, 32'd1);
      cycles(2);
      rst_n = 1'b0;
      #1;
      check("midframe_reset_tx", {31'd0, tx}, 32'd1);
      check_leds("midframe_reset", 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
